vga_rx: RTL and testbench

Video timing receiver and pixel recovery block for the HDMI/VGA path. It samples a 640x480@60 raster (active-high `hsync`/`vsync` pulses and 16-bit RGB565 pixels with no data-enable) and rebuilds the horizontal and vertical counters from the sync edges. It checks the measured timing against the configured totals and locks after consecutive good frames. While locked it outputs pixel coordinates and data for a downstream frame-buffer writer.

---
 rtl/vga_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_rx.sv
// vga_rx: rebuilds raster counters from hsync/vsync edges, checks line and
// frame totals, locks after LOCK_FRAMES good frames, then emits pixel x/y/data.
// Ports: vga_clk, sys_rst_n (async, active-low), hsync, vsync, rgb[15:0] in;
//        pix_x, pix_y, pix_data, pix_valid, frame_start, locked,
//        meas_h_total, meas_v_total, err_cnt out.
// Define VGA_RX_STATS_EN to build meas_h_total/meas_v_total/err_cnt;
// otherwise those outputs are tied to 0.
module vga_rx #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 40,
    parameter int H_LEFT      = 8,
    parameter int H_VALID     = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 25,
    parameter int V_TOP       = 8,
    parameter int V_VALID     = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  meas_h_total,
    output logic [9:0]  meas_v_total,
    output logic [7:0]  err_cnt
);
    localparam logic [9:0]  H_LO   = 10'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [9:0]  H_HI   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);
    localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BACK + V_TOP + V_VALID - 1);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    logic        hs_dly_q;
    logic [15:0] rgb_dly_q;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        vs_line_q, vs_line_d;
    logic        frame_bad_q, frame_bad_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        frame_start_q, frame_start_d;
    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    logic        hrise, vrise, h_sat, line_bad, frame_good, in_win, lock_c;
    logic [10:0] h_len, v_len;

    // Lengths are one past the last counter value; 11 bits so a saturated
    // counter never aliases to a legal total.
    always_comb begin
        hrise      = hsync && !hs_dly_q;
        vrise      = hrise && vsync && !vs_line_q;
        h_sat      = (h_cnt_q == 10'h3FF);
        h_len      = {1'b0, h_cnt_q} + 11'd1;
        v_len      = {1'b0, v_cnt_q} + 11'd1;
        line_bad   = hrise && (h_len != H_TOT);
        // The line closing at vrise still belongs to the ending frame.
        frame_good = (v_len == V_TOT) && !frame_bad_q && !line_bad;
        in_win     = (h_cnt_q >= H_LO) && (h_cnt_q <= H_HI) &&
                     (v_cnt_q >= V_LO) && (v_cnt_q <= V_HI);
    end

    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        vs_line_d   = vs_line_q;
        frame_bad_d = frame_bad_q | line_bad;
        if (hrise) begin
            h_cnt_d   = '0;
            vs_line_d = vsync;
        end else if (!h_sat) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
        if (vrise) begin
            v_cnt_d     = '0;
            frame_bad_d = 1'b0;
        end else if (hrise && v_cnt_q != 10'h3FF) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end
        frame_start_d = vrise;
        pix_valid_d   = in_win && lock_c;
        pix_x_d       = pix_valid_d ? h_cnt_q - H_LO : 10'h3FF;
        pix_y_d       = pix_valid_d ? v_cnt_q - V_LO : 10'h3FF;
        pix_data_d    = pix_valid_d ? rgb_dly_q : 16'h0;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_dly_q      <= 1'b0;
            rgb_dly_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vs_line_q     <= 1'b0;
            frame_bad_q   <= 1'b0;
            pix_x_q       <= 10'h3FF;
            pix_y_q       <= 10'h3FF;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_dly_q      <= hsync;
            rgb_dly_q     <= rgb;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_line_q     <= vs_line_d;
            frame_bad_q   <= frame_bad_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        unique case (state_q)
            SEARCH: begin
                if (vrise) begin
                    state_d    = CHECK;
                    good_cnt_d = '0;
                end
            end
            CHECK: begin
                if (h_sat) begin
                    state_d = SEARCH;
                end else if (vrise) begin
                    if (!frame_good) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (h_sat || line_bad || (vrise && !frame_good)) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        lock_c = (state_q == LOCKED);
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = lock_c;

`ifdef VGA_RX_STATS_EN
    logic       first_h_q, first_h_d;
    logic       first_v_q, first_v_d;
    logic [9:0] meas_h_q, meas_h_d;
    logic [9:0] meas_v_q, meas_v_d;
    logic [7:0] err_q, err_d;
    logic       loss;

    // A coincident bad line and bad frame is still a single transition.
    assign loss = lock_c && (state_d == SEARCH);

    always_comb begin
        first_h_d = first_h_q;
        first_v_d = first_v_q;
        meas_h_d  = meas_h_q;
        meas_v_d  = meas_v_q;
        err_d     = err_q;
        // The first edge after reset closes a partial line/frame.
        if (hrise) begin
            first_h_d = 1'b0;
            if (!first_h_q) meas_h_d = h_len[9:0];
        end
        if (vrise) begin
            first_v_d = 1'b0;
            if (!first_v_q) meas_v_d = v_len[9:0];
        end
        if (loss && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            first_h_q <= 1'b1;
            first_v_q <= 1'b1;
            meas_h_q  <= '0;
            meas_v_q  <= '0;
            err_q     <= '0;
        end else begin
            first_h_q <= first_h_d;
            first_v_q <= first_v_d;
            meas_h_q  <= meas_h_d;
            meas_v_q  <= meas_v_d;
            err_q     <= err_d;
        end
    end

    assign meas_h_total = meas_h_q;
    assign meas_v_total = meas_v_q;
    assign err_cnt      = err_q;
`else
    assign meas_h_total = '0;
    assign meas_v_total = '0;
    assign err_cnt      = '0;
`endif
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed raster sequences on a scaled-down timing with a
// pixel scoreboard; checks lock, loss, relock, stats and reset behaviour.
module tb_vga_rx;
    localparam int HS = 4, HBK = 2, HL = 1, HV = 8, HT = 20;
    localparam int VS = 2, VBK = 2, VTP = 1, VV = 6, VT = 14;
    localparam int HA = HS + HBK + HL;
    localparam int VA = VS + VBK + VTP;
`ifdef VGA_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst_n, hsync, vsync;
    logic [15:0] rgb;
    logic [9:0]  pix_x, pix_y, meas_h_total, meas_v_total;
    logic [15:0] pix_data;
    logic        pix_valid, frame_start, locked;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;
    int nvalid = 0;
    logic [35:0] sb[$];

    vga_rx #(
        .H_SYNC(HS), .H_BACK(HBK), .H_LEFT(HL), .H_VALID(HV), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VBK), .V_TOP(VTP), .V_VALID(VV), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(clk), .sys_rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] st(input int v);
        return STATS ? 36'(v) : 36'd0;
    endfunction

    task automatic chk(input string tag, input logic [35:0] got,
                       input logic [35:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit exp_fs);
        logic [35:0] e;
        @(posedge clk);
        #1;
        chk("frame_start", 36'(frame_start), 36'(exp_fs));
        if (pix_valid === 1'b1) begin
            nvalid++;
            chk("sb_nonempty", 36'(sb.size() != 0), 36'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pixel", {pix_x, pix_y, pix_data}, e);
            end
        end else begin
            chk("idle_pix", {pix_x, pix_y, pix_data},
                {10'h3FF, 10'h3FF, 16'h0});
        end
    endtask

    task automatic drive_line(input int v, input int len, input bit lk);
        for (int h = 0; h < len; h++) begin
            hsync = (h < HS);
            vsync = (v < VS);
            rgb   = 16'(h ^ v);
            if (lk && h >= HA && h < HA + HV && v >= VA && v < VA + VV)
                sb.push_back({10'(h - HA), 10'(v - VA), 16'(h ^ v)});
            tick(h == 0 && v == 0);
        end
    endtask

    task automatic drive_frame(input int nl, input int badv, input bit lk,
                               input int mh, input int mv, input int er);
        nvalid = 0;
        for (int v = 0; v < nl; v++) begin
            drive_line(v, (v == badv) ? HT + 1 : HT, lk);
            if (v == 0) begin
                chk("locked", 36'(locked), 36'(lk));
                if (mh >= 0) chk("meas_h", 36'(meas_h_total), st(mh));
                chk("meas_v", 36'(meas_v_total), st(mv));
                chk("err_cnt", 36'(err_cnt), st(er));
            end
            if (badv >= 0 && v == badv + 1) begin
                chk("loss_locked", 36'(locked), 36'd0);
                chk("loss_err", 36'(err_cnt), st(er + 1));
                chk("loss_meas_h", 36'(meas_h_total), st(HT + 1));
            end
        end
        chk("valid_count", 36'(nvalid), lk ? 36'(HV * VV) : 36'd0);
        chk("sb_empty", 36'(sb.size()), 36'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_pix", {pix_x, pix_y, pix_data}, {10'h3FF, 10'h3FF, 16'h0});
        chk("rst_flags", {33'd0, pix_valid, frame_start, locked}, 36'd0);
        chk("rst_stats", {8'd0, meas_h_total, meas_v_total, err_cnt}, 36'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = '0;
        repeat (3) tick(1'b0);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (5) tick(1'b0);

        // acquire: lock after third frame start
        drive_frame(VT, -1, 1'b0, 0, 0, 0);
        drive_frame(VT, -1, 1'b0, HT, VT, 0);
        drive_frame(VT, -1, 1'b1, HT, VT, 0);
        drive_frame(VT, -1, 1'b1, HT, VT, 0);

        // one long line while locked, then relock
        drive_frame(VT, 12, 1'b1, HT, VT, 0);
        drive_frame(VT, -1, 1'b0, HT, VT, 1);
        drive_frame(VT, -1, 1'b0, HT, VT, 1);
        drive_frame(VT, -1, 1'b1, HT, VT, 1);

        // hsync stuck low past counter saturation
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (1100) tick(1'b0);
        chk("sat_locked", 36'(locked), 36'd0);
        chk("sat_err", 36'(err_cnt), st(2));

        // short frame during CHECK clears good count
        drive_frame(VT, -1, 1'b0, -1, VT, 2);
        drive_frame(VT - 1, -1, 1'b0, HT, VT, 2);
        drive_frame(VT, -1, 1'b0, HT, VT - 1, 2);
        drive_frame(VT, -1, 1'b0, HT, VT, 2);
        drive_frame(VT, -1, 1'b1, HT, VT, 2);

        // reset mid-line while locked
        for (int v = 0; v < 7; v++) drive_line(v, HT, 1'b1);
        chk("pre_rst_locked", 36'(locked), 36'd1);
        drive_line(7, 10, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        sb.delete();
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) tick(1'b0);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (2) tick(1'b0);
        drive_frame(VT, -1, 1'b0, 0, 0, 0);
        drive_frame(VT, -1, 1'b0, HT, VT, 0);
        drive_frame(VT, -1, 1'b1, HT, VT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
